md_unit: RTL and testbench

- Multiply/divide unit in the execute stage. Owns the HI/LO registers.
- Executes mult, multu, div, divu, mthi and mtlo, and supplies HI/LO to the execute-stage result mux for mfhi/mflo.
- Produces the decode-stage stall request. Results reach the memory stage through the normal ALU-output path.

---
 rtl/md_unit_pkg.sv | 33 +++
 rtl/md_divider.sv | 49 ++++
 rtl/md_unit.sv | 141 ++++++++++++++
 tb/tb_md_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// controller states and cycle-count constants.
package md_unit_pkg;

  // Operation codes on MDOpE. The signed divide is called MD_DIVS so that
  // its name does not collide with the MD_DIV controller state.
  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIVS  = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  // Controller states
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2
  } md_state_t;

  // Busy-cycle counts. The divide count is tied to the one-bit-per-cycle
  // divider and must stay at 32.
  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES          = 32;
  localparam int CNT_W               = 6;

  // Two's-complement negate when neg is set, pass-through otherwise
  function automatic logic [31:0] apply_sign(input logic [31:0] value,
                                             input logic        neg);
    return neg ? (32'd0 - value) : value;
  endfunction

endpackage

// File: rtl/md_divider.sv
// 32-step restoring unsigned divider. Load latches the operands; every step
// shifts in one dividend bit and produces one quotient bit. The outputs
// present the values after the step being applied this cycle, so the owner
// can capture the final iteration on the same edge that performs it.
module md_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [31:0] shifted_low;
  logic        q_bit;

  // One restoring iteration: the partial remainder is shifted left taking
  // the next dividend bit; a set top bit means it already exceeds any
  // 32-bit divisor, so the subtraction always succeeds in that case.
  always_comb begin
    shifted_low = {rem_q[30:0], quo_q[31]};
    q_bit       = rem_q[31] | (shifted_low >= dvs_q);
    quotient    = {quo_q[30:0], q_bit};
    remainder   = q_bit ? (shifted_low - dvs_q) : shifted_low;
  end

  // Iteration registers: the quotient register doubles as the dividend
  // shift register, emptying from the top as quotient bits enter below.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (step) begin
      rem_q <= remainder;
      quo_q <= quotient;
    end
  end

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit. Owns HI/LO, runs multi-cycle
// mult/div operations, handles mthi/mtlo and raises the decode stall.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        InterruptRequest,
  input  logic        StartE,
  input  logic [2:0]  MDOpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        UseMDD,
  output logic        Busy,
  output logic        StallMD,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_state_t        state;
  md_state_t        state_next;
  logic [CNT_W-1:0] count;
  logic [63:0]      product;
  logic             quo_neg;
  logic             rem_neg;
  logic             div_zero;
  logic             start_ok;
  logic             is_signed;
  logic             is_mult;
  logic             is_div;
  logic             last;
  logic             div_load;
  logic             div_step;
  logic [31:0]      dvd_abs;
  logic [31:0]      dvs_abs;
  logic [31:0]      quotient;
  logic [31:0]      remainder;

  // Start qualification and operand decoding shared by all processes
  always_comb begin
    start_ok  = StartE & ~InterruptRequest & (state == MD_IDLE);
    is_mult   = (MDOpE == MD_MULT) | (MDOpE == MD_MULTU);
    is_div    = (MDOpE == MD_DIVS) | (MDOpE == MD_DIVU);
    is_signed = (MDOpE == MD_MULT) | (MDOpE == MD_DIVS);
    last      = (count == CNT_W'(1));
    dvd_abs   = apply_sign(SrcAE, is_signed & SrcAE[31]);
    dvs_abs   = apply_sign(SrcBE, is_signed & SrcBE[31]);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= MD_IDLE;
    else        state <= state_next;
  end

  // Next-state logic: both busy states leave on the last counted cycle
  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: begin
        if (start_ok && is_mult)     state_next = MD_MUL;
        else if (start_ok && is_div) state_next = MD_DIV;
      end
      MD_MUL:  if (last) state_next = MD_IDLE;
      MD_DIV:  if (last) state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  // Outputs decoded from the registered state, plus the divider controls
  always_comb begin
    Busy     = (state != MD_IDLE);
    StallMD  = UseMDD & (Busy | StartE);
    div_load = start_ok & is_div;
    div_step = (state == MD_DIV);
  end

  // Busy-cycle counter: loaded at start, counts down to 1 on the last cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (start_ok && is_mult) begin
      count <= CNT_W'(MULT_CYCLES);
    end else if (start_ok && is_div) begin
      count <= CNT_W'(DIV_CYCLES);
    end else if (state != MD_IDLE) begin
      count <= count - CNT_W'(1);
    end
  end

  // Operand capture: the full product is formed at start and held until
  // write-back; divides remember the result signs and a zero divisor
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      product  <= '0;
      quo_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
    end else if (start_ok && is_mult) begin
      product <= {{32{is_signed & SrcAE[31]}}, SrcAE} *
                 {{32{is_signed & SrcBE[31]}}, SrcBE};
    end else if (start_ok && is_div) begin
      quo_neg  <= is_signed & (SrcAE[31] ^ SrcBE[31]);
      rem_neg  <= is_signed & SrcAE[31];
      div_zero <= (SrcBE == 32'd0);
    end
  end

  // HI/LO write-back: moves at the start edge, arithmetic results only on
  // the edge that ends the last busy cycle; a zero divisor leaves them alone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      HI <= '0;
      LO <= '0;
    end else if (start_ok && (MDOpE == MD_MTHI)) begin
      HI <= SrcAE;
    end else if (start_ok && (MDOpE == MD_MTLO)) begin
      LO <= SrcAE;
    end else if ((state == MD_MUL) && last) begin
      HI <= product[63:32];
      LO <= product[31:0];
    end else if ((state == MD_DIV) && last && !div_zero) begin
      HI <= apply_sign(remainder, rem_neg);
      LO <= apply_sign(quotient, quo_neg);
    end
  end

  md_divider u_divider (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .step      (div_step),
    .dividend  (dvd_abs),
    .divisor   (dvs_abs),
    .quotient  (quotient),
    .remainder (remainder)
  );

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a table of operations with hand-computed
// HI/LO and busy lengths, followed by stall, flush, overlap and reset cases.
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        InterruptRequest = 1'b0;
  logic        StartE = 1'b0;
  logic [2:0]  MDOpE = 3'b000;
  logic [31:0] SrcAE = '0;
  logic [31:0] SrcBE = '0;
  logic        UseMDD = 1'b0;
  logic        Busy;
  logic        StallMD;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          busy;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  md_unit dut (
    .clk              (clk),
    .reset            (reset),
    .InterruptRequest (InterruptRequest),
    .StartE           (StartE),
    .MDOpE            (MDOpE),
    .SrcAE            (SrcAE),
    .SrcBE            (SrcBE),
    .UseMDD           (UseMDD),
    .Busy             (Busy),
    .StallMD          (StallMD),
    .HI               (HI),
    .LO               (LO)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Present one operation for a single cycle; returns at the negedge after
  // the start edge, i.e. in the first busy cycle
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b);
    @(negedge clk);
    StartE = 1'b1;
    MDOpE  = op;
    SrcAE  = a;
    SrcBE  = b;
    @(negedge clk);
    StartE = 1'b0;
  endtask

  // Count busy cycles until idle, bounded
  task automatic waitIdle(output int n);
    n = 0;
    while (Busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int          n;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    vecs[0]  = '{"mult_neg1x2",   MD_MULT,  32'hFFFFFFFF, 32'd2,        5,  32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{"multu_max_x2",  MD_MULTU, 32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{"div_m7_2",      MD_DIVS,  32'hFFFFFFF9, 32'd2,        32, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"divu_100_7",    MD_DIVU,  32'd100,      32'd7,        32, 32'd2,        32'd14};
    vecs[4]  = '{"div_min_m1",    MD_DIVS,  32'h80000000, 32'hFFFFFFFF, 32, 32'h00000000, 32'h80000000};
    vecs[5]  = '{"mthi_11",       MD_MTHI,  32'h11,       32'd0,        0,  32'h00000011, 32'h80000000};
    vecs[6]  = '{"mtlo_22",       MD_MTLO,  32'h22,       32'd0,        0,  32'h00000011, 32'h00000022};
    vecs[7]  = '{"div_5_0",       MD_DIVS,  32'd5,        32'd0,        32, 32'h00000011, 32'h00000022};
    vecs[8]  = '{"mult_7_m3",     MD_MULT,  32'd7,        32'hFFFFFFFD, 5,  32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[9]  = '{"divu_max_16",   MD_DIVU,  32'hFFFFFFFF, 32'd16,       32, 32'h0000000F, 32'h0FFFFFFF};
    vecs[10] = '{"div_7_m2",      MD_DIVS,  32'd7,        32'hFFFFFFFE, 32, 32'h00000001, 32'hFFFFFFFD};
    vecs[11] = '{"multu_max_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};

    // Reset state
    #12;
    checkOutput("reset_busy", 32'(Busy), 32'd0);
    checkOutput("reset_hi", HI, 32'd0);
    checkOutput("reset_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven operations
    prev_hi = 32'd0;
    prev_lo = 32'd0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      if (vecs[i].busy > 0) begin
        checkOutput({vecs[i].name, "_hi_early"}, HI, prev_hi);
        checkOutput({vecs[i].name, "_lo_early"}, LO, prev_lo);
      end
      waitIdle(n);
      checkOutput({vecs[i].name, "_busy_cycles"}, 32'(n), 32'(vecs[i].busy));
      checkOutput({vecs[i].name, "_hi"}, HI, vecs[i].hi);
      checkOutput({vecs[i].name, "_lo"}, LO, vecs[i].lo);
      prev_hi = vecs[i].hi;
      prev_lo = vecs[i].lo;
    end

    // Stall covers the start cycle and every busy cycle of a mult
    @(negedge clk);
    UseMDD = 1'b1;
    StartE = 1'b1;
    MDOpE  = MD_MULT;
    SrcAE  = 32'd3;
    SrcBE  = 32'd4;
    #1;
    checkOutput("stall_start_cycle", 32'(StallMD), 32'd1);
    @(negedge clk);
    StartE = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("stall_busy_cycle", 32'({Busy, StallMD}), 32'd3);
      @(negedge clk);
    end
    #1;
    checkOutput("stall_released", 32'(StallMD), 32'd0);
    checkOutput("stall_hi", HI, 32'd0);
    checkOutput("stall_lo", LO, 32'd12);
    UseMDD = 1'b0;

    // Flushed mthi leaves HI alone
    InterruptRequest = 1'b1;
    applyStimulus(MD_MTHI, 32'hABCD, 32'd0);
    InterruptRequest = 1'b0;
    checkOutput("flush_mthi_hi", HI, 32'd0);
    checkOutput("flush_mthi_busy", 32'(Busy), 32'd0);

    // Second start during a divide is ignored
    applyStimulus(MD_DIVU, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    StartE = 1'b1;
    MDOpE  = MD_MULT;
    SrcAE  = 32'd2;
    SrcBE  = 32'd3;
    @(negedge clk);
    StartE = 1'b0;
    waitIdle(n);
    checkOutput("overlap_busy_cycles", 32'(n + 3), 32'd32);
    checkOutput("overlap_hi", HI, 32'd2);
    checkOutput("overlap_lo", LO, 32'd14);

    // Asynchronous reset in busy cycle 10 of a divide
    applyStimulus(MD_DIVS, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_busy", 32'(Busy), 32'd0);
    checkOutput("async_reset_hi", HI, 32'd0);
    checkOutput("async_reset_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(MD_MTLO, 32'd5, 32'd0);
    checkOutput("post_reset_lo", LO, 32'd5);
    checkOutput("post_reset_hi", HI, 32'd0);
    checkOutput("post_reset_busy", 32'(Busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
